// File: rtl/mxv_frame_loader_pkg.sv
// Shared types and frame constants for the MxV front-end loader.
// Frame layout on the wire: SOF, L, CMD, payload, EOF.
package mxv_frame_loader_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] addr_t;
    typedef logic [2:0] bank_sel_t;

    localparam byte_t SOF       = 8'hFE;
    localparam byte_t EOF       = 8'hEF;
    localparam byte_t CMD_SIZE  = 8'h01;
    localparam byte_t CMD_START = 8'h03;
    localparam byte_t CMD_MAT   = 8'h04;
    localparam byte_t CMD_VEC   = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_CMD  = 3'd2,
        ST_DATA = 3'd3,
        ST_END  = 3'd4
    } state_t;

endpackage

// File: rtl/mxv_frame_loader_bank_ram.sv
// One 16x8 row bank: synchronous write, registered read-first output.
// The storage array is deliberately left unreset; only the output register clears.
module mxv_bank_ram
    import mxv_frame_loader_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  byte_t wr_data,
    input  logic  rd_en,
    input  addr_t rd_addr,
    output byte_t rd_data
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Same-edge read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mxv_frame_loader.sv
// MxV front-end: parses UART command frames, fills row banks and the vector
// register, and produces the op_start pulse and the divided tick enable.
module mxv_frame_loader
    import mxv_frame_loader_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NBANKS  = 8,
    parameter int DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rd_en,
    input  logic [2:0]  rd_bank,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [63:0] vec_data,
    output logic [3:0]  mat_size,
    output logic        op_start,
    output logic        frame_err,
    output logic        tick,
    output state_t      dbg_state
);

    // Handshake: rx_data is consumed on every rising edge where rx_valid=1;
    // there is no back-pressure, so the parser must accept a byte every cycle.

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    state_t    state;
    byte_t     len;
    byte_t     cmd;
    byte_t     remaining;
    byte_t     pend_size;
    byte_t     k;
    logic [3:0] row;
    logic [3:0] col;
    logic      mat_wr;
    bank_sel_t rd_bank_q;
    logic [CW-1:0] div_cnt;
    byte_t     bank_rd [NBANKS];

    assign dbg_state = state;

    // Row/column counters replace k/N and k%N; writing stops once row reaches N.
    assign mat_wr = rx_valid && (state == ST_DATA) && (cmd == CMD_MAT) && (row < mat_size);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            cmd       <= '0;
            remaining <= '0;
            pend_size <= '0;
            k         <= '0;
            row       <= '0;
            col       <= '0;
            mat_size  <= '0;
            vec_data  <= '0;
            op_start  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            op_start  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SOF) state <= ST_LEN;
                    end
                    ST_LEN: begin
                        len <= rx_data;
                        if (rx_data < 8'd2) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd       <= rx_data;
                        remaining <= len - 8'd2;
                        k         <= '0;
                        row       <= '0;
                        col       <= '0;
                        pend_size <= '0;
                        state     <= (len == 8'd2) ? ST_END : ST_DATA;
                    end
                    ST_DATA: begin
                        remaining <= remaining - 8'd1;
                        k         <= k + 8'd1;
                        if (remaining == 8'd1) state <= ST_END;
                        case (cmd)
                            CMD_SIZE: begin
                                if (k == 8'd0) pend_size <= rx_data;
                            end
                            CMD_VEC: begin
                                if (k < {4'd0, mat_size}) vec_data[{k[2:0], 3'b000} +: 8] <= rx_data;
                            end
                            CMD_MAT: begin
                                if (mat_wr) begin
                                    if (col == mat_size - 4'd1) begin
                                        col <= '0;
                                        row <= row + 4'd1;
                                    end else begin
                                        col <= col + 4'd1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_END: begin
                        state <= ST_IDLE;
                        if (rx_data == EOF) begin
                            if (cmd == CMD_SIZE) begin
                                if (pend_size == 8'd0 || pend_size > 8'd8) frame_err <= 1'b1;
                                else mat_size <= pend_size[3:0];
                            end else if (cmd == CMD_START) begin
                                op_start <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        mxv_bank_ram #(.DEPTH(DEPTH)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (mat_wr && (row[2:0] == bank_sel_t'(i))),
            .wr_addr (col),
            .wr_data (rx_data),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[i])
        );
    end

    // All banks read together; the registered bank select picks the result.
    always_ff @(posedge clk) begin
        if (rst)        rd_bank_q <= '0;
        else if (rd_en) rd_bank_q <= rd_bank;
    end

    assign rd_data = bank_rd[rd_bank_q];

    always_ff @(posedge clk) begin
        if (rst)                              div_cnt <= '0;
        else if (div_cnt == CW'(CLK_DIV - 1)) div_cnt <= '0;
        else                                  div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: tb/tb_mxv_frame_loader.sv
// Directed bench for mxv_frame_loader: frame parsing, bank loads, vector
// loads, start/error pulses, read-first collision and the tick divider.
module tb_mxv_frame_loader;
    import mxv_frame_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_en;
    logic [2:0]  rd_bank;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [63:0] vec_data;
    logic [3:0]  mat_size;
    logic        op_start;
    logic        frame_err;
    logic        tick;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxv_frame_loader #(.CLK_DIV(4), .NBANKS(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .vec_data  (vec_data),
        .mat_size  (mat_size),
        .op_start  (op_start),
        .frame_err (frame_err),
        .tick      (tick),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is taken at the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic read_word(input logic [2:0] bank, input logic [3:0] addr);
        rd_en   = 1'b1;
        rd_bank = bank;
        rd_addr = addr;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_rd_data", rd_data, 0);
        check("rst_vec_data", vec_data, 0);
        check("rst_mat_size", mat_size, 0);
        check("rst_op_start", op_start, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        for (int c = 0; c < 12; c++) begin
            check("tick", tick, (c % 4 == 3) ? 1 : 0);
            @(negedge clk);
        end

        // Size frame, bytes back to back; 0xFF before SOF is ignored.
        send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
        check("size_before_eof", mat_size, 0);
        send_byte(8'hEF);
        check("size_after_eof", mat_size, 2);
        check("size_no_err", frame_err, 0);

        // 2x2 matrix load.
        send_byte(8'hFE); send_byte(8'h06); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hEF);
        check("mat_no_err", frame_err, 0);
        read_word(3'd0, 4'd0); check("rd_b0_a0", rd_data, 8'h01);
        read_word(3'd0, 4'd1); check("rd_b0_a1", rd_data, 8'h02);
        read_word(3'd1, 4'd0); check("rd_b1_a0", rd_data, 8'h03);
        read_word(3'd1, 4'd1); check("rd_b1_a1", rd_data, 8'h04);
        rd_bank = 3'd0; rd_addr = 4'd0;
        @(negedge clk);
        check("rd_hold", rd_data, 8'h04);

        // Vector loads; the third payload byte lies beyond N=2.
        send_byte(8'hFE); send_byte(8'h04); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'hEF);
        check("vec_two", vec_data, 64'h0201);
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h05);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        send_byte(8'hEF);
        check("vec_drop", vec_data, 64'h0B0A);

        // Start command: single-cycle pulse after the EOF edge.
        send_byte(8'hFE); send_byte(8'h02); send_byte(8'h03); send_byte(8'hEF);
        check("start_pulse", op_start, 1);
        check("start_no_err", frame_err, 0);
        @(negedge clk);
        check("start_one_cycle", op_start, 0);

        // Start with a bad terminator.
        send_byte(8'hFE); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
        check("bad_eof_err", frame_err, 1);
        check("bad_eof_no_start", op_start, 0);
        @(negedge clk);
        check("bad_eof_err_clear", frame_err, 0);

        // Length below 2.
        send_byte(8'hFE); send_byte(8'h01);
        check("short_len_err", frame_err, 1);
        check("short_len_idle", dbg_state, ST_IDLE);

        // Illegal size value.
        send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h09); send_byte(8'hEF);
        check("size9_err", frame_err, 1);
        check("size9_keep", mat_size, 2);

        // Write and read of bank0/addr0 on the same edge.
        send_byte(8'hFE); send_byte(8'h03); send_byte(8'h04);
        rd_en = 1'b1; rd_bank = 3'd0; rd_addr = 4'd0;
        send_byte(8'h55);
        rd_en = 1'b0;
        check("collision_old", rd_data, 8'h01);
        send_byte(8'hEF);
        read_word(3'd0, 4'd0);
        check("collision_new", rd_data, 8'h55);

        // Reset in the middle of a size frame.
        send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_size", mat_size, 0);
        check("midrst_vec", vec_data, 0);
        check("midrst_state", dbg_state, ST_IDLE);

        // With N=0 matrix bytes are dropped; banks keep contents across reset.
        send_byte(8'hFE); send_byte(8'h03); send_byte(8'h04); send_byte(8'h77); send_byte(8'hEF);
        read_word(3'd0, 4'd0);
        check("n0_drop", rd_data, 8'h55);

        send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h04); send_byte(8'hEF);
        check("clean_size", mat_size, 4);
        check("clean_no_err", frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxv_frame_loader.md
Name: mxv_frame_loader

Overview:
- Front-end of the matrix-by-vector (MxV) engine.
- Parses byte-framed commands from the UART receiver and captures the matrix size.
- Writes matrix elements into 8 row banks (16x8 each) and vector elements into a 64-bit register.
- Issues an operation-start pulse and a divided clock-enable tick for the downstream processor, which reads the banks through a synchronous read port.

Parameters:
- CLK_DIV, 4, tick period in clk cycles (legal range 2..256).
- NBANKS, 8, number of row banks; also the maximum matrix size.
- DEPTH, 16, words per bank; address width 4.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rd_en  in  1  bank read request.
- rd_bank  in  3  bank (row) to read.
- rd_addr  in  4  word (column) to read.
- rd_data  out  8  registered read data.
- vec_data  out  64  vector register; element i is in bits [8i+7:8i].
- mat_size  out  4  current matrix size N.
- op_start  out  1  one-cycle start pulse.
- frame_err  out  1  one-cycle error pulse.
- tick  out  1  clock-enable, high 1 cycle every CLK_DIV cycles.

Behaviour:
- Reset values: rd_data=0, vec_data=0, mat_size=0, op_start=0, frame_err=0, tick=0, divider counter=0, FSM=IDLE. Bank contents are not reset.
- Frame format: 0xFE, L, CMD, payload (L-2 bytes), 0xEF. L counts CMD, payload and the 0xEF byte.
- FSM advances only on clock edges with rx_valid=1. States and transitions:
  - IDLE: 0xFE -> LEN. Any other byte (including 0xFF) is ignored.
  - LEN: store L. L<2 -> frame_err pulse, go to IDLE. Otherwise -> CMD.
  - CMD: store CMD, set remaining=L-2. remaining=0 -> END, else -> DATA.
  - DATA: process the byte, decrement remaining, go to END when it reaches 0. 0xFE/0xEF in DATA are ordinary data.
  - END: 0xEF -> commit, go to IDLE. Any other byte -> frame_err pulse, no commit, go to IDLE.
- CMD 0x01 (set size): the first payload byte is latched as pending size and applied to mat_size at commit. Values 0 or >8 -> frame_err pulse at commit, mat_size unchanged.
- CMD 0x03 (start): op_start pulses the cycle after the 0xEF edge. Payload bytes are ignored.
- CMD 0x04 (load matrix):
  - Payload byte k is written at the same edge it is accepted, to bank k/N, address k%N, using N=mat_size.
  - Bytes with k >= N*N are dropped.
  - If N=0, all bytes are dropped.
  - Writes are not rolled back on frame error.
- CMD 0x05 (load vector): payload byte i loads vec_data[8i+7:8i] at acceptance, for i < N. Further bytes are dropped.
- Any other CMD: payload is consumed with no effect; 0xEF still required.
- Read port: rd_en at edge t -> rd_data = bank[rd_bank][rd_addr] after edge t. rd_data holds its value when rd_en=0.
- Read/write collision (same bank and address, same edge): returns old data (read-first).
- Divider: counter runs 0..CLK_DIV-1 and wraps. tick=1 for the cycle while counter==CLK_DIV-1. Free-running, independent of the FSM.
- Reset asserted mid-frame: FSM returns to IDLE, partial frame discarded, mat_size and vec_data cleared.
- op_start and frame_err never assert in the same cycle.

Decomposition:
- Shared package: byte_t (8 bits); addr_t (4 bits); bank_sel_t (3 bits); constants SOF=0xFE, EOF=0xEF, CMD_SIZE=0x01, CMD_START=0x03, CMD_MAT=0x04, CMD_VEC=0x05; FSM state enum.
- Sub-module mxv_bank_ram: one 16x8 bank with synchronous write and registered read-first output. Instantiate 8 times; the top muxes rd_data by rd_bank.

Test Plan:
- Size: FF FE 03 01 02 EF -> mat_size=2 after the EF edge; no frame_err.
- Matrix: after size=2, send FE 06 04 01 02 03 04 EF; read bank0 addr0/1 -> 01/02 and bank1 addr0/1 -> 03/04, each one cycle after rd_en.
- Vector: after size=2, send FE 04 05 01 02 EF -> vec_data[15:0]=0x0201, upper bits 0. A third payload byte is dropped.
- Start: FE 02 03 EF -> exactly one op_start cycle. Replacing the EF with 0x00 -> frame_err pulse, no op_start.
- Errors: FE 01 -> frame_err. FE 03 01 09 EF -> frame_err, mat_size unchanged. Reset mid-frame, then a clean size frame -> accepted.
- Tick: with CLK_DIV=4 after reset, tick high on cycles 3, 7, 11… for 1 cycle each. Bench also checks rx_valid strobes spaced 1 cycle apart are all accepted.
